systolic_pe: RTL and testbench

Parametrised output-stationary processing element for the systolic array, successor to the fixed 8-bit MAC cell. Each cell forwards signed operands east/south with a valid/last sideband, and accumulates a dot product of programmable length framed by `i_last`. It then parks the finished result in a result register that is part of a per-column shift-out chain. Accumulation of the next tile overlaps draining of the previous one.

---
 rtl/systolic_pe.sv | 90 +++++++++
 tb/tb_systolic_pe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe.sv
// systolic_pe: output-stationary MAC cell with operand forwarding and a per-column result drain chain.
// Define SYSTOLIC_PE_SAT_EN to saturate the accumulator and report clamps on o_ovf.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_valid,
    output logic              o_last,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    input  logic              i_shift,
    input  logic [ACC_W-1:0]  i_res,
    input  logic              i_res_valid,
    output logic [ACC_W-1:0]  o_res,
    output logic              o_res_valid,
    output logic              o_collide,
    output logic              o_ovf
);
    typedef enum logic {FIRST, RUN} state_t;
`ifdef SYSTOLIC_PE_SAT_EN
    localparam int SW = ACC_W + 1;
`else
    localparam int SW = ACC_W;
`endif
    state_t state, state_nx;
    logic signed [ACC_W-1:0] acc, acc_nx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [SW-1:0] sum;
    logic load;
    assign prod = $signed(i_a) * $signed(i_b);
    assign sum  = (state == RUN ? SW'(acc) : '0) + SW'(prod);
    assign load = i_valid & i_last;
`ifdef SYSTOLIC_PE_SAT_EN
    logic clamp;
    // Both addends fit in ACC_W bits, so overflow shows as the top two sum bits disagreeing
    assign clamp  = sum[ACC_W] != sum[ACC_W-1];
    assign acc_nx = clamp ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                          : sum[ACC_W-1:0];
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_ovf <= 1'b0;
        else if (i_valid && clamp)
            o_ovf <= 1'b1;
    end
`else
    assign acc_nx = sum[ACC_W-1:0];
    assign o_ovf  = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        if (i_valid)
            state_nx = i_last ? FIRST : RUN;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= FIRST;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_a         <= '0;
            o_b         <= '0;
            acc         <= '0;
            o_res       <= '0;
            o_res_valid <= 1'b0;
            o_collide   <= 1'b0;
        end else begin
            state   <= state_nx;
            o_valid <= i_valid;
            o_last  <= i_last;
            o_a     <= i_a;
            o_b     <= i_b;
            if (i_valid)
                acc <= acc_nx;
            if (load) begin
                o_res       <= acc_nx;
                o_res_valid <= 1'b1;
            end else if (i_shift) begin
                o_res       <= i_res;
                o_res_valid <= i_res_valid;
            end
            if (load && i_shift)
                o_collide <= 1'b1;
        end
    end
endmodule

// File: tb/tb_systolic_pe.sv
// tb_systolic_pe: vector table on the chain head, then hand sequences for drain, collision and overflow.
module tb_systolic_pe;
    localparam int DW = 8;
    localparam int AW = 24;

    typedef struct {
        logic rst_n, v, l, sh;
        logic signed [DW-1:0] a, b;
        logic ov, ol;
        logic signed [DW-1:0] oa, ob;
        logic signed [AW-1:0] res;
        logic rv;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sh;
    logic v[4], l[4];
    logic signed [DW-1:0] a[4], b[4];
    logic ov[3], ol[3], col[3], ovf[3];
    logic signed [DW-1:0] oa[3], ob[3];
    logic signed [AW-1:0] rc[4];
    logic rvc[4];
    logic ov3, ol3, rv3, col3, ovf3;
    logic signed [DW-1:0] oa3, ob3;
    logic signed [15:0] res3;

    int n_chk = 0;
    int n_fail = 0;

    assign rc[0]  = '0;
    assign rvc[0] = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : pe
        systolic_pe #(.DATA_W(DW), .ACC_W(AW)) u (
            .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[g]), .i_last(l[g]),
            .i_a(a[g]), .i_b(b[g]), .o_valid(ov[g]), .o_last(ol[g]),
            .o_a(oa[g]), .o_b(ob[g]), .i_shift(sh), .i_res(rc[g]),
            .i_res_valid(rvc[g]), .o_res(rc[g+1]), .o_res_valid(rvc[g+1]),
            .o_collide(col[g]), .o_ovf(ovf[g])
        );
    end

    systolic_pe #(.DATA_W(DW), .ACC_W(16)) u_ovf (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[3]), .i_last(l[3]),
        .i_a(a[3]), .i_b(b[3]), .o_valid(ov3), .o_last(ol3),
        .o_a(oa3), .o_b(ob3), .i_shift(1'b0), .i_res(16'd0),
        .i_res_valid(1'b0), .o_res(res3), .o_res_valid(rv3),
        .o_collide(col3), .o_ovf(ovf3)
    );

    function automatic vec_t mk(logic rst_n_, logic v_, logic l_, logic sh_,
                                int a_, int b_, logic ov_, logic ol_, int oa_, int ob_,
                                int res_, logic rv_);
        vec_t t;
        t.rst_n = rst_n_; t.v = v_; t.l = l_; t.sh = sh_;
        t.a = DW'(a_); t.b = DW'(b_);
        t.ov = ov_; t.ol = ol_; t.oa = DW'(oa_); t.ob = DW'(ob_);
        t.res = AW'(res_); t.rv = rv_;
        return t;
    endfunction

    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        sh = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b0; l[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tv[19];
    logic signed [15:0] exp_ovf_res;
    logic exp_ovf;

    initial begin
        rst_n = 1'b0;
        idle();
        tv[0]  = mk(0, 1, 1, 1,   55,  -3, 0, 0,    0,   0,     0, 0);
        tv[1]  = mk(0, 1, 0, 0,   -1,  77, 0, 0,    0,   0,     0, 0);
        tv[2]  = mk(1, 1, 0, 0,    3,   4, 1, 0,    3,   4,     0, 0);
        tv[3]  = mk(1, 1, 0, 0,   -2,   5, 1, 0,   -2,   5,     0, 0);
        tv[4]  = mk(1, 1, 0, 0,  127, 127, 1, 0,  127, 127,     0, 0);
        tv[5]  = mk(1, 1, 1, 0, -128,   1, 1, 1, -128,   1, 16003, 1);
        tv[6]  = mk(1, 0, 0, 0,    9,   9, 0, 0,    9,   9, 16003, 1);
        tv[7]  = mk(1, 1, 0, 0,    3,   4, 1, 0,    3,   4, 16003, 1);
        tv[8]  = mk(1, 0, 0, 0,   50,  50, 0, 0,   50,  50, 16003, 1);
        tv[9]  = mk(1, 1, 0, 0,   -2,   5, 1, 0,   -2,   5, 16003, 1);
        tv[10] = mk(1, 1, 0, 0,  127, 127, 1, 0,  127, 127, 16003, 1);
        tv[11] = mk(1, 0, 1, 0,  -50,  -1, 0, 1,  -50,  -1, 16003, 1);
        tv[12] = mk(1, 1, 1, 0, -128,   1, 1, 1, -128,   1, 16003, 1);
        tv[13] = mk(1, 1, 1, 0,   -7,   6, 1, 1,   -7,   6,   -42, 1);
        tv[14] = mk(1, 0, 1, 0,    1,   1, 0, 1,    1,   1,   -42, 1);
        tv[15] = mk(1, 1, 0, 0,   10,  10, 1, 0,   10,  10,   -42, 1);
        tv[16] = mk(0, 1, 1, 1,    9,   9, 0, 0,    0,   0,     0, 0);
        tv[17] = mk(1, 1, 1, 0,    2,   3, 1, 1,    2,   3,     6, 1);
        tv[18] = mk(1, 0, 0, 1,    0,   0, 0, 0,    0,   0,     0, 0);

        for (int i = 0; i < 19; i++) begin
            rst_n = tv[i].rst_n;
            v[0] = tv[i].v; l[0] = tv[i].l; a[0] = tv[i].a; b[0] = tv[i].b;
            sh = tv[i].sh;
            step();
            chk($sformatf("vec%0d_o_valid", i), ov[0], tv[i].ov);
            chk($sformatf("vec%0d_o_last", i), ol[0], tv[i].ol);
            chk($sformatf("vec%0d_o_a", i), oa[0], tv[i].oa);
            chk($sformatf("vec%0d_o_b", i), ob[0], tv[i].ob);
            chk($sformatf("vec%0d_o_res", i), rc[1], tv[i].res);
            chk($sformatf("vec%0d_o_res_valid", i), rvc[1], tv[i].rv);
            if (!tv[i].rst_n) begin
                chk($sformatf("vec%0d_collide_rst", i), col[0], 0);
                chk($sformatf("vec%0d_ovf_rst", i), ovf[0], 0);
                chk($sformatf("vec%0d_tail_res_rst", i), rc[3], 0);
            end
        end

        idle();
        v[0] = 1; l[0] = 1; a[0] = 2; b[0] = 5;
        v[1] = 1; l[1] = 1; a[1] = 4; b[1] = 5;
        v[2] = 1; l[2] = 1; a[2] = 5; b[2] = 6;
        step();
        chk("load_head", rc[1], 10);
        chk("load_mid", rc[2], 20);
        chk("load_tail", rc[3], 30);
        chk("load_tail_valid", rvc[3], 1);
        idle();
        sh = 1;
        step();
        chk("drain1_tail", rc[3], 20);
        chk("drain1_tail_valid", rvc[3], 1);
        step();
        chk("drain2_tail", rc[3], 10);
        chk("drain2_tail_valid", rvc[3], 1);
        step();
        chk("drain3_tail", rc[3], 0);
        chk("drain3_tail_valid", rvc[3], 0);
        chk("drain_no_collide", col[2], 0);

        idle();
        v[0] = 1; l[0] = 1; a[0] = 3; b[0] = 3;
        step();
        chk("coll_upstream", rc[1], 9);
        idle();
        v[1] = 1; l[1] = 1; a[1] = 5; b[1] = 11; sh = 1;
        step();
        chk("coll_res", rc[2], 55);
        chk("coll_res_valid", rvc[2], 1);
        chk("coll_flag", col[1], 1);
        chk("coll_head_shifted", rc[1], 0);
        idle();
        step();
        chk("coll_sticky", col[1], 1);
        chk("coll_head_clear", col[0], 0);
        chk("coll_tail_clear", col[2], 0);
        chk("no_ovf_head", ovf[0], 0);

`ifdef SYSTOLIC_PE_SAT_EN
        exp_ovf_res = 16'sd32767;
        exp_ovf = 1'b1;
`else
        exp_ovf_res = -16'sd17149;
        exp_ovf = 1'b0;
`endif
        idle();
        v[3] = 1; a[3] = 127; b[3] = 127;
        step();
        step();
        chk("ovf_pre", ovf3, 0);
        l[3] = 1;
        step();
        chk("ovf_res", res3, exp_ovf_res);
        chk("ovf_flag", ovf3, exp_ovf);
        idle();
        step();
        chk("ovf_hold", ovf3, exp_ovf);
        chk("ovf_res_hold", res3, exp_ovf_res);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
